mul_err_sweep_ctrl: RTL and testbench

- Sequential controller for exhaustive error evaluation of one combinational approximate unsigned WIDTH x WIDTH multiplier netlist, instantiated outside this block.
- Drives every operand pair into the multiplier under test and computes the exact product internally.
- Accumulates error count, sum of absolute error and maximum absolute error, then reports them through a start/busy/done handshake.
- Sits between the evaluation testbench or top and each generated multiplier variant.

---
 rtl/mul_err_sweep_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mul_err_sweep_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_err_sweep_ctrl.sv
// mul_err_sweep_ctrl: exhaustive error sweep controller for one combinational
// WIDTH x WIDTH approximate unsigned multiplier under test.
// Steps every operand pair {op_a, op_b} through the multiplier, one per cycle,
// then accumulates error count, sum of |error| and max |error| through a
// two-stage pipeline. Handshake: start -> busy -> done.
// Optional macro MUL_ERR_SWEEP_BIAS_EN adds the signed error-sum output err_bias.
module mul_err_sweep_ctrl #(
  parameter int unsigned WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic [WIDTH-1:0]       op_a,
  output logic [WIDTH-1:0]       op_b,
  input  logic [2*WIDTH-1:0]     approx_p,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH:0]       err_count,
  output logic [4*WIDTH-1:0]     err_sum,
`ifdef MUL_ERR_SWEEP_BIAS_EN
  output logic [2*WIDTH-1:0]     err_max,
  output logic signed [4*WIDTH:0] err_bias
`else
  output logic [2*WIDTH-1:0]     err_max
`endif
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               valid_q, valid_d;
  logic [PW-1:0]      approx_q, approx_d;
  logic [PW-1:0]      exact_q, exact_d;
  logic [PW:0]        err_count_q, err_count_d;
  logic [4*WIDTH-1:0] err_sum_q, err_sum_d;
  logic [PW-1:0]      err_max_q, err_max_d;
`ifdef MUL_ERR_SWEEP_BIAS_EN
  logic signed [4*WIDTH:0] err_bias_q, err_bias_d;
`endif

  logic [PW-1:0] mag;
  logic [PW-1:0] vec_nxt;
  logic          last_vec;
  logic          acc_en;
  logic          clr_acc;

  // Stage-2 absolute error between registered approximate and exact products
  always_comb begin
    mag = (approx_q >= exact_q) ? (approx_q - exact_q) : (exact_q - approx_q);
  end

  // Next-state, operand stepping, stage-1 capture and accumulation
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    valid_d     = 1'b0;
    approx_d    = approx_q;
    exact_d     = exact_q;
    err_count_d = err_count_q;
    err_sum_d   = err_sum_q;
    err_max_d   = err_max_q;
`ifdef MUL_ERR_SWEEP_BIAS_EN
    err_bias_d  = err_bias_q;
`endif
    acc_en      = 1'b0;
    clr_acc     = 1'b0;
    vec_nxt     = {op_a_q, op_b_q} + PW'(1);
    last_vec    = &{op_a_q, op_b_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          op_a_d  = '0;
          op_b_d  = '0;
          clr_acc = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          valid_d  = 1'b1;
          approx_d = approx_p;
          exact_d  = {{WIDTH{1'b0}}, op_a_q} * {{WIDTH{1'b0}}, op_b_q};
          // the +1 wraps the operand pair back to 0 after the last vector
          {op_a_d, op_b_d} = vec_nxt;
          acc_en   = valid_q;
          if (last_vec) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          acc_en  = valid_q;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clr_acc) begin
      err_count_d = '0;
      err_sum_d   = '0;
      err_max_d   = '0;
`ifdef MUL_ERR_SWEEP_BIAS_EN
      err_bias_d  = '0;
`endif
    end else if (acc_en) begin
      if (mag != '0) begin
        err_count_d = err_count_q + (PW+1)'(1);
      end
      err_sum_d = err_sum_q + (4*WIDTH)'(mag);
      if (mag > err_max_q) begin
        err_max_d = mag;
      end
`ifdef MUL_ERR_SWEEP_BIAS_EN
      // zero-extended operands; modular subtraction yields the signed difference
      err_bias_d = err_bias_q + ((4*WIDTH+1)'(approx_q) - (4*WIDTH+1)'(exact_q));
`endif
    end

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      approx_q    <= '0;
      exact_q     <= '0;
      err_count_q <= '0;
      err_sum_q   <= '0;
      err_max_q   <= '0;
`ifdef MUL_ERR_SWEEP_BIAS_EN
      err_bias_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      approx_q    <= approx_d;
      exact_q     <= exact_d;
      err_count_q <= err_count_d;
      err_sum_q   <= err_sum_d;
      err_max_q   <= err_max_d;
`ifdef MUL_ERR_SWEEP_BIAS_EN
      err_bias_q  <= err_bias_d;
`endif
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_count_q;
  assign err_sum   = err_sum_q;
  assign err_max   = err_max_q;
`ifdef MUL_ERR_SWEEP_BIAS_EN
  assign err_bias  = err_bias_q;
`endif

endmodule

// File: tb/tb_mul_err_sweep_ctrl.sv
// Self-checking bench for mul_err_sweep_ctrl (WIDTH = 6).
// A spec-level model tracks sweep progress by cycle number and sums errors per
// vector with plain integer arithmetic; a negedge process compares every cycle.
module tb_mul_err_sweep_ctrl;

  localparam int W  = 6;
  localparam int NV = 1 << (2 * W);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [W-1:0]      op_a, op_b;
  logic [2*W-1:0]    approx_p;
  logic              busy, done;
  logic [2*W:0]      err_count;
  logic [4*W-1:0]    err_sum;
  logic [2*W-1:0]    err_max;
`ifdef MUL_ERR_SWEEP_BIAS_EN
  logic signed [4*W:0] err_bias;
`endif

  int mode = 0;
  int rtab [NV];
  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  mul_err_sweep_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .approx_p(approx_p),
    .busy(busy), .done(done),
    .err_count(err_count), .err_sum(err_sum),
`ifdef MUL_ERR_SWEEP_BIAS_EN
    .err_max(err_max), .err_bias(err_bias)
`else
    .err_max(err_max)
`endif
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: 0 exact, 1 zero, 2 product|1, 3 random table
  function automatic int approx_of(input int md, input int a, input int b);
    case (md)
      0: return a * b;
      1: return 0;
      2: return (a * b) | 1;
      default: return rtab[a * (1 << W) + b];
    endcase
  endfunction

  assign approx_p = (2*W)'(approx_of(mode, int'(op_a), int'(op_b)));

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 sweeping (m_n = cycle number since start), 2 done
  int     m_phase = 0;
  int     m_n = 0;
  bit     m_op_known = 1'b1;
  longint m_cnt = 0, m_sum = 0, m_max = 0, m_bias = 0;

  task automatic m_clear();
    m_cnt = 0; m_sum = 0; m_max = 0; m_bias = 0;
  endtask

  task automatic m_acc(input int k);
    int a, b;
    longint diff, d;
    a = k / (1 << W);
    b = k % (1 << W);
    diff = longint'(approx_of(mode, a, b)) - longint'(a * b);
    d = (diff < 0) ? -diff : diff;
    if (d != 0) m_cnt++;
    m_sum += d;
    if (d > m_max) m_max = d;
    m_bias += diff;
  endtask

  // Vector k is presented in sweep cycle k+1 and folded into the totals at the
  // end of sweep cycle k+2; the sweep completes at the end of cycle NV+1.
  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_n = 0; m_op_known = 1'b1; m_clear();
    end else begin
      case (m_phase)
        1: begin
          if (abort) begin
            m_phase = 0; m_op_known = 1'b0;
          end else begin
            if (m_n >= 2) m_acc(m_n - 2);
            m_n++;
            if (m_n == NV + 2) m_phase = 2;
          end
        end
        default: begin
          if (start) begin
            m_phase = 1; m_n = 1; m_op_known = 1'b1; m_clear();
          end
        end
      endcase
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int vec;
      vec = (m_phase == 1 && m_n <= NV) ? (m_n - 1) : 0;
      check("busy", longint'(busy), longint'(m_phase == 1));
      check("done", longint'(done), longint'(m_phase == 2));
      if (m_op_known) begin
        check("op_a", longint'(op_a), longint'(vec / (1 << W)));
        check("op_b", longint'(op_b), longint'(vec % (1 << W)));
      end
      check("err_count", longint'(err_count), m_cnt);
      check("err_sum", longint'(err_sum), m_sum);
      check("err_max", longint'(err_max), m_max);
`ifdef MUL_ERR_SWEEP_BIAS_EN
      check("err_bias", longint'(err_bias), m_bias);
`endif
    end
  end

  // One sweep: start in cycle 0; optional abort / rst / extra starts at given cycles
  task automatic run(input int md, input int abort_at, input int rst_at,
                     input bit extra, output int lat, output int busy_cnt);
    int c;
    @(negedge clk);
    mode = md;
    start = 1'b1;
    c = 0; lat = -1; busy_cnt = 0;
    while (c < NV + 200) begin
      @(negedge clk);
      c++;
      busy_cnt += int'(busy);
      if (done) begin lat = c; break; end
      start = extra && (c == 10 || c == NV + 1);
      abort = (c == abort_at);
      rst   = (c == rst_at);
      if ((abort_at > 0 && c == abort_at + 3) || (rst_at > 0 && c == rst_at + 3)) break;
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    if (abort_at == 0 && rst_at == 0) begin
      check("done_latency", longint'(lat), longint'(NV + 2));
      check("busy_cycles", longint'(busy_cnt), longint'(NV + 1));
    end
  endtask

  initial begin
    int lat, bc;
    for (int k = 0; k < NV; k++) begin
      if ($urandom_range(0, 1) == 1) rtab[k] = (k / (1 << W)) * (k % (1 << W));
      else rtab[k] = int'($urandom_range(0, NV - 1));
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // exact multiplier
    run(0, 0, 0, 1'b0, lat, bc);
    check("exact_count", longint'(err_count), 0);
    check("exact_sum", longint'(err_sum), 0);
    check("exact_max", longint'(err_max), 0);

    // product forced to zero
    run(1, 0, 0, 1'b0, lat, bc);
    check("zero_count", longint'(err_count), 3969);
    check("zero_sum", longint'(err_sum), 4064256);
    check("zero_max", longint'(err_max), 3969);
`ifdef MUL_ERR_SWEEP_BIAS_EN
    check("zero_bias", longint'(err_bias), -4064256);
`endif

    // product | 1, with starts during RUN and DRAIN that must be ignored
    run(2, 0, 0, 1'b1, lat, bc);
    check("or1_count", longint'(err_count), 3072);
    check("or1_sum", longint'(err_sum), 3072);
    check("or1_max", longint'(err_max), 1);
`ifdef MUL_ERR_SWEEP_BIAS_EN
    check("or1_bias", longint'(err_bias), 3072);
`endif
    // restart from DONE repeats identical totals
    run(2, 0, 0, 1'b0, lat, bc);
    check("or1_rerun_count", longint'(err_count), 3072);
    check("or1_rerun_sum", longint'(err_sum), 3072);
    check("or1_rerun_max", longint'(err_max), 1);

    // abort at cycle 100: vectors 0..97 counted (a=1, b=1..33 are the errors)
    run(1, 100, 0, 1'b0, lat, bc);
    check("abort_done", longint'(done), 0);
    check("abort_busy", longint'(busy), 0);
    check("abort_count", longint'(err_count), 33);
    check("abort_sum", longint'(err_sum), 561);
    check("abort_max", longint'(err_max), 33);

    // reset mid-run, then clean random sweep
    run(3, 0, 2000, 1'b0, lat, bc);
    check("rst_count", longint'(err_count), 0);
    check("rst_op_a", longint'(op_a), 0);
    run(3, 0, 0, 1'b0, lat, bc);

    // abort coinciding with RUN->DRAIN, then abort at a random point
    run(3, NV, 0, 1'b0, lat, bc);
    check("abort_last_done", longint'(done), 0);
    run(3, int'($urandom_range(2, NV + 1)), 0, 1'b0, lat, bc);
    run(3, 0, 0, 1'b0, lat, bc);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
